// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data-memory port: registered ownership, round-robin with a burst limit.
// Define DMEM_ARB_FIXED_PRIO_EN to give master 0 fixed priority instead of round-robin.
module dmem_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state_o
);

    localparam int CNT_W = $clog2(BURST_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(BURST_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    state_t            both_pick;
    logic              preempt0;
    logic              preempt1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign both_pick = OWN0;
    assign preempt0  = 1'b0;
    assign preempt1  = 1'b1;
`else
    logic burst_done;
    // >= rather than ==: an owner whose uncontended run already passed the
    // limit must still yield on the first contended edge.
    assign burst_done = (cnt_q >= CNT_LIM);
    assign both_pick  = last_q ? OWN0 : OWN1;
    assign preempt0   = burst_done;
    assign preempt1   = burst_done;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) state_d = both_pick;
                else if (m0_req)      state_d = OWN0;
                else if (m1_req)      state_d = OWN1;
            end
            OWN0: begin
                if (!m0_req)                  state_d = m1_req ? OWN1 : IDLE;
                else if (m1_req && preempt0)  state_d = OWN1;
            end
            OWN1: begin
                if (!m1_req)                  state_d = m0_req ? OWN0 : IDLE;
                else if (m0_req && preempt1)  state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            cnt_d = '0;
        end else if (state_d != state_q) begin
            cnt_d  = '0;
            last_d = (state_d == OWN1);
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Grants are gated by the live request so a dropped request never writes.
    assign m0_gnt = (state_q == OWN0) && m0_req;
    assign m1_gnt = (state_q == OWN1) && m1_req;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    assign m0_rdata    = m0_gnt ? mem_rdata : '0;
    assign m1_rdata    = m1_gnt ? mem_rdata : '0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against an ownership model.
module tb_dmem_arbiter;
    localparam int BM = 4;
    localparam int W  = 32;

    logic         clk = 1'b0;
    logic         nreset;
    logic         m0_req, m0_we, m1_req, m1_we;
    logic [W-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic         m0_gnt, m1_gnt, mem_we;
    logic [W-1:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.BURST_MAX(BM), .DATA_W(W)) dut (
        .clk(clk), .nreset(nreset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
    );

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset = 0;
        idle_inputs();
        @(negedge clk);
        nreset = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nreset = 0;
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEAD; mem_rdata = 32'h55;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({m0_gnt, m1_gnt, mem_we} !== 3'b000) begin
                failures++;
                $display("FAIL reset_ctrl: gnt0=%b gnt1=%b we=%b required 0", m0_gnt, m1_gnt, mem_we);
            end
            checks++;
            if ((mem_addr | mem_wdata | m0_rdata | m1_rdata) !== '0) begin
                failures++;
                $display("FAIL reset_data: addr=%h wdata=%h rd0=%h rd1=%h required 0",
                         mem_addr, mem_wdata, m0_rdata, m1_rdata);
            end
        end
        nreset = 1;
        #1;
        checks++;
        if (m0_gnt !== 1'b0) begin
            failures++;
            $display("FAIL release_same_cycle: gnt0=%b required 0", m0_gnt);
        end
        @(negedge clk); #1;
        checks++;
        if (m0_gnt !== 1'b1 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL release_grant: gnt0=%b we=%b required 1 1", m0_gnt, mem_we);
        end
        #1 nreset = 0;
        #1;
        checks++;
        if (m0_gnt !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_write: gnt0=%b we=%b required 0 0", m0_gnt, mem_we);
        end
        @(negedge clk);
        idle_inputs();
        nreset = 1;
    endtask

    task automatic test_single_read();
        do_reset();
        m1_req = 1; m1_addr = 32'h40; mem_rdata = 32'h1234;
        #1;
        checks++;
        if (m1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL read_latency: gnt1=%b required 0 in request cycle", m1_gnt);
        end
        @(negedge clk); #1;
        checks++;
        if (m1_gnt !== 1'b1 || m1_rdata !== 32'h1234 || m0_rdata !== '0) begin
            failures++;
            $display("FAIL single_read: gnt1=%b rd1=%h rd0=%h required 1 1234 0", m1_gnt, m1_rdata, m0_rdata);
        end
        checks++;
        if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL read_bus: addr=%h we=%b required 40 0", mem_addr, mem_we);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_write_mux();
        do_reset();
        m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEAD;
        m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wdata = 32'hCAFE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'hCAFE) begin
                failures++;
                $display("FAIL write_mux: we=%b addr=%h wdata=%h required 1 80 cafe", mem_we, mem_addr, mem_wdata);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_early_release();
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 32'h4; m1_addr = 32'h8;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
                failures++;
                $display("FAIL early_owner: cycle=%0d gnt0=%b gnt1=%b required 1 0", i, m0_gnt, m1_gnt);
            end
        end
        @(negedge clk);
        m0_req = 0;
        #1;
        checks++;
        if (m0_gnt !== 1'b0) begin
            failures++;
            $display("FAIL drop_gnt: gnt0=%b required 0", m0_gnt);
        end
        @(negedge clk); #1;
        checks++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
            failures++;
            $display("FAIL early_handoff: gnt0=%b gnt1=%b required 0 1", m0_gnt, m1_gnt);
        end
        @(negedge clk);
        idle_inputs();
    endtask

`ifdef DMEM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        do_reset();
        m1_req = 1;
        @(negedge clk); #1;
        checks++;
        if (m1_gnt !== 1'b1) begin
            failures++;
            $display("FAIL prio_m1_own: gnt1=%b required 1", m1_gnt);
        end
        @(negedge clk);
        m0_req = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            checks++;
            if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
                failures++;
                $display("FAIL prio_preempt: cycle=%0d gnt0=%b gnt1=%b required 1 0", i, m0_gnt, m1_gnt);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask
`else
    task automatic test_contention();
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 32'h100; m1_addr = 32'h200;
        #1;
        checks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL contend_idle: gnt0=%b gnt1=%b required 0 0", m0_gnt, m1_gnt);
        end
        for (int i = 0; i < 4 * BM; i++) begin
            logic [1:0] exp_g;
            @(negedge clk); #1;
            exp_g = ((i / BM) % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({m1_gnt, m0_gnt} !== exp_g) begin
                failures++;
                $display("FAIL contention: cycle=%0d gnt1gnt0=%b required %b", i, {m1_gnt, m0_gnt}, exp_g);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        int           owner = -1;
        int           run   = 0;
        int           last  = 1;
        logic         r0, r1, eg0, eg1, pg0, pg1, ewe;
        logic [W-1:0] eaddr, ewdata;
        pg0 = 0; pg1 = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (m0_req && pg0) begin
                if ($urandom_range(0, 2) == 0) m0_req = 0;
                else begin m0_we = 1'($urandom_range(0, 1)); m0_addr = $urandom; m0_wdata = $urandom; end
            end else if (!m0_req && $urandom_range(0, 1) == 1) begin
                m0_req = 1; m0_we = 1'($urandom_range(0, 1)); m0_addr = $urandom; m0_wdata = $urandom;
            end
            if (m1_req && pg1) begin
                if ($urandom_range(0, 2) == 0) m1_req = 0;
                else begin m1_we = 1'($urandom_range(0, 1)); m1_addr = $urandom; m1_wdata = $urandom; end
            end else if (!m1_req && $urandom_range(0, 1) == 1) begin
                m1_req = 1; m1_we = 1'($urandom_range(0, 1)); m1_addr = $urandom; m1_wdata = $urandom;
            end
            mem_rdata = $urandom;
            r0 = m0_req; r1 = m1_req;
            eg0 = (owner == 0) && r0;
            eg1 = (owner == 1) && r1;
            ewe = eg0 ? m0_we : (eg1 ? m1_we : 1'b0);
            eaddr = eg0 ? m0_addr : (eg1 ? m1_addr : '0);
            ewdata = eg0 ? m0_wdata : (eg1 ? m1_wdata : '0);
            #1;
            checks++;
            if (m0_gnt !== eg0 || m1_gnt !== eg1) begin
                failures++;
                $display("FAIL rand_gnt: cycle=%0d gnt0=%b gnt1=%b required %b %b", c, m0_gnt, m1_gnt, eg0, eg1);
            end
            checks++;
            if (mem_we !== ewe || mem_addr !== eaddr || mem_wdata !== ewdata) begin
                failures++;
                $display("FAIL rand_bus: cycle=%0d we=%b addr=%h wdata=%h required %b %h %h",
                         c, mem_we, mem_addr, mem_wdata, ewe, eaddr, ewdata);
            end
            checks++;
            if (m0_rdata !== (eg0 ? mem_rdata : '0) || m1_rdata !== (eg1 ? mem_rdata : '0)) begin
                failures++;
                $display("FAIL rand_rdata: cycle=%0d rd0=%h rd1=%h gnt0=%b gnt1=%b src=%h",
                         c, m0_rdata, m1_rdata, eg0, eg1, mem_rdata);
            end
            pg0 = eg0; pg1 = eg1;
            // Decide who owns the port next, from the request/grant history.
            begin
                int  nxt;
                logic mine, other;
                nxt = owner;
                if (eg0 || eg1) run++;
                if (owner < 0) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    if (r0 && r1) nxt = 0;
`else
                    if (r0 && r1) nxt = (last == 0) ? 1 : 0;
`endif
                    else if (r0) nxt = 0;
                    else if (r1) nxt = 1;
                end else begin
                    mine  = (owner == 0) ? r0 : r1;
                    other = (owner == 0) ? r1 : r0;
                    if (!mine) nxt = other ? 1 - owner : -1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    else if (other && owner == 1) nxt = 0;
`else
                    else if (other && run >= BM) nxt = 1 - owner;
`endif
                end
                if (nxt != owner) begin
                    run = 0;
                    if (nxt >= 0) last = nxt;
                end
                owner = nxt;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        nreset = 0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_write_mux();
        test_early_release();
`ifdef DMEM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_contention();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
